// File: rtl/controle_bola.sv
// Ball-motion and scoring controller for Pong: moves the ball on each passo tick,
// bounces it off walls and paddles, detects misses and keeps both scores.
module controle_bola #(
  parameter int LARGURA    = 640,
  parameter int ALTURA     = 480,
  parameter int BOLA       = 8,
  parameter int VEL        = 4,
  parameter int RAQ_ALT    = 64,
  parameter int RAQ_LARG   = 8,
  parameter int RAQ_E_X    = 16,
  parameter int RAQ_D_X    = 616,
  parameter int PONTOS_MAX = 9
) (
  input  logic       clock,
  input  logic       zera_s,
  input  logic       inicia,
  input  logic       passo,
  input  logic [9:0] raquete_e_y,
  input  logic [9:0] raquete_d_y,
  output logic [9:0] bola_x,
  output logic [9:0] bola_y,
  output logic       dir_x,
  output logic       dir_y,
  output logic [3:0] placar_e,
  output logic [3:0] placar_d,
  output logic       ponto_e,
  output logic       ponto_d,
  output logic       em_jogo,
  output logic       fim_jogo
);

  typedef enum logic [1:0] {
    ESPERA = 2'd0,
    JOGO   = 2'd1,
    PONTO  = 2'd2,
    FIM    = 2'd3
  } estado_t;

  // Comparison constants are 11 bits wide so sums like y+BOLA+VEL never wrap
  localparam logic [10:0] K_LARG    = 11'(LARGURA);
  localparam logic [10:0] K_ALT     = 11'(ALTURA);
  localparam logic [10:0] K_BOLA    = 11'(BOLA);
  localparam logic [10:0] K_VEL     = 11'(VEL);
  localparam logic [10:0] K_RAQ_ALT = 11'(RAQ_ALT);
  localparam logic [10:0] K_FACE_E  = 11'(RAQ_E_X + RAQ_LARG);
  localparam logic [10:0] K_FACE_D  = 11'(RAQ_D_X - BOLA);

  localparam logic [9:0] C_X      = 10'((LARGURA - BOLA) / 2);
  localparam logic [9:0] C_Y      = 10'((ALTURA - BOLA) / 2);
  localparam logic [9:0] C_VEL    = 10'(VEL);
  localparam logic [9:0] C_Y_MAX  = 10'(ALTURA - BOLA);
  localparam logic [9:0] C_FACE_E = 10'(RAQ_E_X + RAQ_LARG);
  localparam logic [9:0] C_FACE_D = 10'(RAQ_D_X - BOLA);
  localparam logic [3:0] C_MAX    = 4'(PONTOS_MAX);

  estado_t    r_estado;
  logic [9:0] r_x, r_y;
  logic       r_dx, r_dy;
  logic [3:0] r_pe, r_pd;
  logic       r_ponto_e, r_ponto_d, r_em, r_fim;
  logic       r_ultimo_d;

  estado_t    w_estado;
  logic [9:0] w_x, w_y, w_x_mov, w_y_mov;
  logic       w_dx, w_dy, w_dx_mov, w_dy_mov;
  logic [3:0] w_pe, w_pd;
  logic       w_ultimo_d;
  logic       w_saiu_esq, w_saiu_dir;
  logic       w_sob_e, w_sob_d;
  logic [10:0] w_x11, w_y11, w_pe11, w_pd11;

  assign w_x11  = {1'b0, r_x};
  assign w_y11  = {1'b0, r_y};
  assign w_pe11 = {1'b0, raquete_e_y};
  assign w_pd11 = {1'b0, raquete_d_y};
  assign w_sob_e = (w_y11 + K_BOLA > w_pe11) && (w_y11 < w_pe11 + K_RAQ_ALT);
  assign w_sob_d = (w_y11 + K_BOLA > w_pd11) && (w_y11 < w_pd11 + K_RAQ_ALT);

  // Candidate ball move for this tick: wall bounce, paddle bounce or miss
  always_comb begin
    w_y_mov    = r_y;
    w_dy_mov   = r_dy;
    w_x_mov    = r_x;
    w_dx_mov   = r_dx;
    w_saiu_esq = 1'b0;
    w_saiu_dir = 1'b0;
    if (r_dy) begin
      if (w_y11 + K_BOLA + K_VEL >= K_ALT) begin
        w_y_mov  = C_Y_MAX;
        w_dy_mov = 1'b0;
      end else begin
        w_y_mov = r_y + C_VEL;
      end
    end else begin
      if (w_y11 <= K_VEL) begin
        w_y_mov  = 10'd0;
        w_dy_mov = 1'b1;
      end else begin
        w_y_mov = r_y - C_VEL;
      end
    end
    if (!r_dx) begin
      if (w_x11 >= K_FACE_E && w_x11 <= K_FACE_E + K_VEL && w_sob_e) begin
        w_x_mov  = C_FACE_E;
        w_dx_mov = 1'b1;
      end else if (w_x11 <= K_VEL) begin
        w_saiu_esq = 1'b1;
      end else begin
        w_x_mov = r_x - C_VEL;
      end
    end else begin
      if (w_x11 >= K_FACE_D - K_VEL && w_x11 <= K_FACE_D && w_sob_d) begin
        w_x_mov  = C_FACE_D;
        w_dx_mov = 1'b0;
      end else if (w_x11 + K_BOLA + K_VEL >= K_LARG) begin
        w_saiu_dir = 1'b1;
      end else begin
        w_x_mov = r_x + C_VEL;
      end
    end
  end

  // Next-state and next-datapath selection
  always_comb begin
    w_estado   = r_estado;
    w_x        = r_x;
    w_y        = r_y;
    w_dx       = r_dx;
    w_dy       = r_dy;
    w_pe       = r_pe;
    w_pd       = r_pd;
    w_ultimo_d = r_ultimo_d;
    case (r_estado)
      ESPERA: begin
        w_x = C_X;
        w_y = C_Y;
        if (inicia) begin
          w_estado = JOGO;
        end else begin
          w_estado = ESPERA;
        end
      end
      JOGO: begin
        if (!passo) begin
          w_estado = JOGO;
        end else if (w_saiu_esq) begin
          w_pd       = r_pd + 4'd1;
          w_ultimo_d = 1'b1;
          w_estado   = PONTO;
        end else if (w_saiu_dir) begin
          w_pe       = r_pe + 4'd1;
          w_ultimo_d = 1'b0;
          w_estado   = PONTO;
        end else begin
          w_x  = w_x_mov;
          w_y  = w_y_mov;
          w_dx = w_dx_mov;
          w_dy = w_dy_mov;
        end
      end
      PONTO: begin
        w_x  = C_X;
        w_y  = C_Y;
        w_dx = !r_ultimo_d;
        if ((r_ultimo_d ? r_pd : r_pe) == C_MAX) begin
          w_estado = FIM;
        end else begin
          w_estado = ESPERA;
        end
      end
      FIM: begin
        w_x = C_X;
        w_y = C_Y;
        if (inicia) begin
          w_pe     = 4'd0;
          w_pd     = 4'd0;
          w_estado = ESPERA;
        end else begin
          w_estado = FIM;
        end
      end
      default: begin
        w_estado = ESPERA;
        w_x      = C_X;
        w_y      = C_Y;
      end
    endcase
  end

  // State and output registers; status flags are decoded from the next state
  always_ff @(posedge clock) begin
    if (zera_s) begin
      r_estado   <= ESPERA;
      r_x        <= C_X;
      r_y        <= C_Y;
      r_dx       <= 1'b1;
      r_dy       <= 1'b1;
      r_pe       <= 4'd0;
      r_pd       <= 4'd0;
      r_ponto_e  <= 1'b0;
      r_ponto_d  <= 1'b0;
      r_em       <= 1'b0;
      r_fim      <= 1'b0;
      r_ultimo_d <= 1'b0;
    end else begin
      r_estado   <= w_estado;
      r_x        <= w_x;
      r_y        <= w_y;
      r_dx       <= w_dx;
      r_dy       <= w_dy;
      r_pe       <= w_pe;
      r_pd       <= w_pd;
      r_ponto_e  <= (w_estado == PONTO) && !w_ultimo_d;
      r_ponto_d  <= (w_estado == PONTO) && w_ultimo_d;
      r_em       <= (w_estado == JOGO);
      r_fim      <= (w_estado == FIM);
      r_ultimo_d <= w_ultimo_d;
    end
  end

  assign bola_x   = r_x;
  assign bola_y   = r_y;
  assign dir_x    = r_dx;
  assign dir_y    = r_dy;
  assign placar_e = r_pe;
  assign placar_d = r_pd;
  assign ponto_e  = r_ponto_e;
  assign ponto_d  = r_ponto_d;
  assign em_jogo  = r_em;
  assign fim_jogo = r_fim;

endmodule

// File: tb/tb_controle_bola.sv
// Scoreboard bench for controle_bola: stimulus pushes expected snapshots and score
// pulses; a negedge monitor pops and compares them against the DUT outputs.
module tb_controle_bola;

  logic       clock = 1'b0;
  logic       zera_s = 1'b0;
  logic       inicia = 1'b0;
  logic       passo = 1'b0;
  logic [9:0] raquete_e_y = 10'd1000;
  logic [9:0] raquete_d_y = 10'd400;
  logic [9:0] bola_x, bola_y;
  logic       dir_x, dir_y;
  logic [3:0] placar_e, placar_d;
  logic       ponto_e, ponto_d, em_jogo, fim_jogo;

  controle_bola dut (
    .clock(clock), .zera_s(zera_s), .inicia(inicia), .passo(passo),
    .raquete_e_y(raquete_e_y), .raquete_d_y(raquete_d_y),
    .bola_x(bola_x), .bola_y(bola_y), .dir_x(dir_x), .dir_y(dir_y),
    .placar_e(placar_e), .placar_d(placar_d), .ponto_e(ponto_e), .ponto_d(ponto_d),
    .em_jogo(em_jogo), .fim_jogo(fim_jogo)
  );

  always #5 clock = ~clock;

  // snapshot layout: x[33:24] y[23:14] dx[13] dy[12] pe[11:8] pd[7:4] em fim pte ptd
  logic [33:0] exp_q[$];
  logic [33:0] msk_q[$];
  string       nome_q[$];
  logic [5:0]  pto_q[$];
  int n_chk = 0;
  int n_fail = 0;

  logic [33:0] m_esp, m_msk, m_act;
  string       m_nome;
  logic [5:0]  m_pto, m_pto_act;

  always @(negedge clock) begin
    m_act = {bola_x, bola_y, dir_x, dir_y, placar_e, placar_d, em_jogo, fim_jogo, ponto_e, ponto_d};
    if (exp_q.size() > 0) begin
      m_esp  = exp_q.pop_front();
      m_msk  = msk_q.pop_front();
      m_nome = nome_q.pop_front();
      n_chk++;
      if ((m_act & m_msk) !== (m_esp & m_msk)) begin
        n_fail++;
        $display("FAIL %s: got x=%0d y=%0d dx=%0b dy=%0b pe=%0d pd=%0d em=%0b fim=%0b pt=%0b%0b, want x=%0d y=%0d dx=%0b dy=%0b pe=%0d pd=%0d em=%0b fim=%0b pt=%0b%0b (y/dy checked=%0b)",
                 m_nome, m_act[33:24], m_act[23:14], m_act[13], m_act[12], m_act[11:8], m_act[7:4],
                 m_act[3], m_act[2], m_act[1], m_act[0],
                 m_esp[33:24], m_esp[23:14], m_esp[13], m_esp[12], m_esp[11:8], m_esp[7:4],
                 m_esp[3], m_esp[2], m_esp[1], m_esp[0], m_msk[12]);
      end
    end
    if (ponto_e || ponto_d) begin
      n_chk++;
      m_pto_act = {ponto_e, ponto_d, (ponto_e ? placar_e : placar_d)};
      if (pto_q.size() == 0) begin
        n_fail++;
        $display("FAIL ponto_inesperado: got e=%0b d=%0b placar=%0d, want no pulse",
                 ponto_e, ponto_d, m_pto_act[3:0]);
      end else begin
        m_pto = pto_q.pop_front();
        if (m_pto_act !== m_pto) begin
          n_fail++;
          $display("FAIL ponto: got e=%0b d=%0b placar=%0d, want e=%0b d=%0b placar=%0d",
                   m_pto_act[5], m_pto_act[4], m_pto_act[3:0], m_pto[5], m_pto[4], m_pto[3:0]);
        end
      end
    end
  end

  task automatic tick(input logic i, input logic p, input logic z);
    inicia = i;
    passo  = p;
    zera_s = z;
    @(posedge clock);
    #1;
    inicia = 1'b0;
    passo  = 1'b0;
    zera_s = 1'b0;
  endtask

  task automatic passos(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 1'b1, 1'b0);
  endtask

  task automatic esp(input string n, input int x, input int y, input logic dx, input logic dy,
                     input int pe, input int pd, input logic em, input logic fim,
                     input logic pte, input logic ptd, input logic cuida_y);
    logic [33:0] m;
    m = '1;
    if (!cuida_y) begin
      m[23:14] = 10'd0;
      m[12]    = 1'b0;
    end
    exp_q.push_back({10'(x), 10'(y), dx, dy, 4'(pe), 4'(pd), em, fim, pte, ptd});
    msk_q.push_back(m);
    nome_q.push_back(n);
  endtask

  task automatic esp_reset(input string n);
    esp(n, 316, 236, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    @(posedge clock);
    #1;
    // Reset, then passo ignored in ESPERA
    tick(1'b0, 1'b0, 1'b1);
    esp_reset("reset");
    passos(5);
    esp_reset("espera_passo");
    // Serve, first move, bottom wall, right paddle
    tick(1'b1, 1'b1, 1'b0);
    esp("serve", 316, 236, 1'b1, 1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    passos(1);
    esp("passo1", 320, 240, 1'b1, 1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    passos(57);
    esp("pre_parede", 548, 468, 1'b1, 1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    passos(1);
    esp("parede", 552, 472, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    passos(13);
    esp("pre_raquete", 604, 420, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    passos(1);
    esp("raquete_d", 608, 416, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Right-side miss and recentre
    tick(1'b0, 1'b0, 1'b1);
    esp_reset("reset2");
    raquete_d_y = 10'd0;
    tick(1'b1, 1'b1, 1'b0);
    esp("serve2", 316, 236, 1'b1, 1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    passos(78);
    esp("pre_falta", 628, 396, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    passos(1);
    esp("ponto_e", 628, 396, 1'b1, 1'b0, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    pto_q.push_back({1'b1, 1'b0, 4'd1});
    tick(1'b0, 1'b0, 1'b0);
    esp("recentra", 316, 236, 1'b1, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-flight
    tick(1'b0, 1'b0, 1'b1);
    esp_reset("reset3");
    tick(1'b1, 1'b1, 1'b0);
    passos(21);
    esp("x400", 400, 320, 1'b1, 1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    esp_reset("reset_voo");

    // Game over: one bounce off the right paddle, then nine left misses
    raquete_d_y = 10'd400;
    tick(1'b1, 1'b1, 1'b0);
    passos(224);
    esp("r1_pre", 4, 0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    passos(1);
    esp("r1_ponto", 4, 0, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    pto_q.push_back({1'b0, 1'b1, 4'd1});
    tick(1'b0, 1'b0, 1'b0);
    esp("r1_espera", 316, 236, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 2; k <= 9; k++) begin
      tick(1'b1, 1'b1, 1'b0);
      passos(79);
      esp("rk_ponto", 4, 0, 1'b0, 1'b0, 0, k, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      pto_q.push_back({1'b0, 1'b1, 4'(k)});
      tick(1'b0, 1'b0, 1'b0);
      esp("rk_depois", 316, 236, 1'b0, 1'b0, 0, k, 1'b0, (k == 9), 1'b0, 1'b0, 1'b0);
    end
    for (int k = 0; k < 3; k++) begin
      passos(1);
      esp("fim_passo", 316, 236, 1'b0, 1'b0, 0, 9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    tick(1'b1, 1'b0, 1'b0);
    esp("fim_inicia", 316, 236, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    passos(1);
    esp("espera_passo2", 316, 236, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset during PONTO: no stale pulse or score survives
    tick(1'b1, 1'b1, 1'b0);
    passos(79);
    esp("ponto_d2", 4, 0, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    pto_q.push_back({1'b0, 1'b1, 4'd1});
    tick(1'b0, 1'b0, 1'b1);
    esp_reset("reset_ponto");
    tick(1'b0, 1'b0, 1'b0);
    esp_reset("sem_pulso");

    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL fila_snap: got %0d pending, want 0", exp_q.size());
    end
    n_chk++;
    if (pto_q.size() != 0) begin
      n_fail++;
      $display("FAIL fila_ponto: got %0d missing pulses, want 0", pto_q.size());
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
